// File: rtl/mc_ctl.sv
// Multicycle MIPS32 main control sequencer: Moore FSM stepping each instruction through fetch/decode/execute/memory/writeback.
// Optional build macro MC_ADDI_EN adds the ADDI path (ADDIEX -> ADDIWB); without it opcode 001000 is illegal.
module mc_ctl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         OpCode,
    input  logic               MemReady,
    output logic               PCWr,
    output logic               PCWrCond,
    output logic [1:0]         PCSrc,
    output logic               IorD,
    output logic               MemRd,
    output logic               MemWr,
    output logic               IRWr,
    output logic               RegDst,
    output logic               RegWr,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               InstrDone,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcwr;
        logic       pcwrcond;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memrd;
        logic       memwr;
        logic       irwr;
        logic       regdst;
        logic       regwr;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       instrdone;
        logic       illegalop;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    ctl_t       ctl, ctl_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        ctl     = '0;
        state_d = S_FETCH;
        op_d    = op_q;
        case (state_q)
            S_FETCH: begin
                ctl.memrd   = 1'b1;
                ctl.alusrcb = 2'b01;
                ctl.irwr    = MemReady;
                ctl.pcwr    = MemReady;
                state_d     = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU computes PC + (imm << 2) here so BRANCH can use ALUOut.
                ctl.alusrcb = 2'b11;
                op_d        = OpCode;
                case (OpCode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:       state_d = S_ADDIEX;
`endif
                    default: begin
                        ctl.illegalop = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
                state_d     = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctl.memrd = 1'b1;
                ctl.iord  = 1'b1;
                state_d   = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctl.regwr     = 1'b1;
                ctl.memtoreg  = 1'b1;
                ctl.instrdone = 1'b1;
            end
            S_MEMWR: begin
                ctl.memwr     = 1'b1;
                ctl.iord      = 1'b1;
                ctl.instrdone = MemReady;
                state_d       = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ctl.alusrca = 1'b1;
                ctl.aluop   = 2'b10;
                state_d     = S_RWB;
            end
            S_RWB: begin
                ctl.regwr     = 1'b1;
                ctl.regdst    = 1'b1;
                ctl.instrdone = 1'b1;
            end
            S_BRANCH: begin
                ctl.alusrca   = 1'b1;
                ctl.aluop     = 2'b01;
                ctl.pcwrcond  = 1'b1;
                ctl.pcsrc     = 2'b01;
                ctl.instrdone = 1'b1;
            end
            S_JUMP: begin
                ctl.pcwr      = 1'b1;
                ctl.pcsrc     = 2'b10;
                ctl.instrdone = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl.regwr     = 1'b1;
                ctl.instrdone = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Reset also masks the FETCH strobes, which would otherwise follow MemReady.
    assign ctl_out = rst ? '0 : ctl;

    assign PCWr      = ctl_out.pcwr;
    assign PCWrCond  = ctl_out.pcwrcond;
    assign PCSrc     = ctl_out.pcsrc;
    assign IorD      = ctl_out.iord;
    assign MemRd     = ctl_out.memrd;
    assign MemWr     = ctl_out.memwr;
    assign IRWr      = ctl_out.irwr;
    assign RegDst    = ctl_out.regdst;
    assign RegWr     = ctl_out.regwr;
    assign MemtoReg  = ctl_out.memtoreg;
    assign ALUSrcA   = ctl_out.alusrca;
    assign ALUSrcB   = ctl_out.alusrcb;
    assign ALUOp     = ctl_out.aluop;
    assign InstrDone = ctl_out.instrdone;
    assign IllegalOp = ctl_out.illegalop;
    assign State     = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctl.sv
// Directed bench for mc_ctl: per-cycle checks of state code and the full control vector.
module tb_mc_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OpCode;
    logic       MemReady;
    logic       PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, RegWr, MemtoReg, ALUSrcA;
    logic       InstrDone, IllegalOp;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    // Control vector bit positions, in the packing order of ctl_vec below.
    localparam logic [17:0] B_PCWR   = 18'h1 << 17;
    localparam logic [17:0] B_PCWRC  = 18'h1 << 16;
    localparam logic [17:0] B_PCS_J  = 18'h1 << 15;
    localparam logic [17:0] B_PCS_BR = 18'h1 << 14;
    localparam logic [17:0] B_IORD   = 18'h1 << 13;
    localparam logic [17:0] B_MEMRD  = 18'h1 << 12;
    localparam logic [17:0] B_MEMWR  = 18'h1 << 11;
    localparam logic [17:0] B_IRWR   = 18'h1 << 10;
    localparam logic [17:0] B_REGDST = 18'h1 << 9;
    localparam logic [17:0] B_REGWR  = 18'h1 << 8;
    localparam logic [17:0] B_M2R    = 18'h1 << 7;
    localparam logic [17:0] B_SRCA   = 18'h1 << 6;
    localparam logic [17:0] B_SRCB_I = 18'h2 << 4;
    localparam logic [17:0] B_SRCB_4 = 18'h1 << 4;
    localparam logic [17:0] B_SRCB_S = 18'h3 << 4;
    localparam logic [17:0] B_OP_FN  = 18'h2 << 2;
    localparam logic [17:0] B_OP_SUB = 18'h1 << 2;
    localparam logic [17:0] B_DONE   = 18'h1 << 1;
    localparam logic [17:0] B_ILL    = 18'h1;

    localparam logic [17:0] E_NONE    = 18'h0;
    localparam logic [17:0] E_FETCH_W = B_MEMRD | B_SRCB_4;
    localparam logic [17:0] E_FETCH_R = B_MEMRD | B_SRCB_4 | B_PCWR | B_IRWR;
    localparam logic [17:0] E_DECODE  = B_SRCB_S;
    localparam logic [17:0] E_DEC_ILL = B_SRCB_S | B_ILL;
    localparam logic [17:0] E_MEMADR  = B_SRCA | B_SRCB_I;
    localparam logic [17:0] E_MEMRD   = B_MEMRD | B_IORD;
    localparam logic [17:0] E_MEMWB   = B_REGWR | B_M2R | B_DONE;
    localparam logic [17:0] E_MEMWR_W = B_MEMWR | B_IORD;
    localparam logic [17:0] E_MEMWR_R = B_MEMWR | B_IORD | B_DONE;
    localparam logic [17:0] E_EXEC    = B_SRCA | B_OP_FN;
    localparam logic [17:0] E_RWB     = B_REGWR | B_REGDST | B_DONE;
    localparam logic [17:0] E_BRANCH  = B_SRCA | B_OP_SUB | B_PCWRC | B_PCS_BR | B_DONE;
    localparam logic [17:0] E_JUMP    = B_PCWR | B_PCS_J | B_DONE;
    localparam logic [17:0] E_ADDIEX  = B_SRCA | B_SRCB_I;
    localparam logic [17:0] E_ADDIWB  = B_REGWR | B_DONE;

    logic [17:0] ctl_vec;
    assign ctl_vec = {PCWr, PCWrCond, PCSrc, IorD, MemRd, MemWr, IRWr, RegDst, RegWr,
                      MemtoReg, ALUSrcA, ALUSrcB, ALUOp, InstrDone, IllegalOp};

    mc_ctl #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .MemReady(MemReady),
        .PCWr(PCWr), .PCWrCond(PCWrCond), .PCSrc(PCSrc), .IorD(IorD),
        .MemRd(MemRd), .MemWr(MemWr), .IRWr(IRWr), .RegDst(RegDst),
        .RegWr(RegWr), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .InstrDone(InstrDone), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp_state, input logic [17:0] exp_ctl);
        total++;
        assert (State === exp_state) else begin
            bad++;
            $error("FAIL %s state: got %0d want %0d", tag, State, exp_state);
        end
        total++;
        assert (ctl_vec === exp_ctl) else begin
            bad++;
            $error("FAIL %s ctl: got %05h want %05h", tag, ctl_vec, exp_ctl);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check before the next rising edge.
    task automatic step(input string tag, input logic [5:0] op, input logic mr,
                        input logic [3:0] exp_state, input logic [17:0] exp_ctl);
        @(negedge clk);
        OpCode   = op;
        MemReady = mr;
        #1;
        chk(tag, exp_state, exp_ctl);
    endtask

    initial begin
        rst      = 1'b1;
        OpCode   = 6'd0;
        MemReady = 1'b1;

        // Reset held 3 cycles with MemReady high: everything quiet.
        step("rst0", 6'd0, 1'b1, 4'd0, E_NONE);
        step("rst1", 6'd0, 1'b1, 4'd0, E_NONE);
        step("rst2", 6'd0, 1'b1, 4'd0, E_NONE);
        rst = 1'b0;
        #1;
        chk("rel_fetch", 4'd0, E_FETCH_R);

        // R-type
        step("r_dec",  6'b000000, 1'b1, 4'd1, E_DECODE);
        step("r_exec", 6'b111111, 1'b0, 4'd6, E_EXEC);
        step("r_rwb",  6'b111111, 1'b0, 4'd7, E_RWB);

        // LW with 2 fetch waits and 3 read waits; live opcode changed after DECODE
        step("lw_fw0",  6'b000000, 1'b0, 4'd0, E_FETCH_W);
        step("lw_fw1",  6'b000000, 1'b0, 4'd0, E_FETCH_W);
        step("lw_fr",   6'b000000, 1'b1, 4'd0, E_FETCH_R);
        step("lw_dec",  6'b100011, 1'b1, 4'd1, E_DECODE);
        step("lw_adr",  6'b101011, 1'b1, 4'd2, E_MEMADR);
        step("lw_rw0",  6'b101011, 1'b0, 4'd3, E_MEMRD);
        step("lw_rw1",  6'b101011, 1'b0, 4'd3, E_MEMRD);
        step("lw_rw2",  6'b101011, 1'b0, 4'd3, E_MEMRD);
        step("lw_rr",   6'b101011, 1'b1, 4'd3, E_MEMRD);
        step("lw_wb",   6'b101011, 1'b0, 4'd4, E_MEMWB);

        // SW with one write wait; live opcode looks like LW in MEMADR
        step("sw_f",    6'b000000, 1'b1, 4'd0, E_FETCH_R);
        step("sw_dec",  6'b101011, 1'b1, 4'd1, E_DECODE);
        step("sw_adr",  6'b100011, 1'b1, 4'd2, E_MEMADR);
        step("sw_ww",   6'b100011, 1'b0, 4'd5, E_MEMWR_W);
        step("sw_wr",   6'b100011, 1'b1, 4'd5, E_MEMWR_R);

        // BEQ, MemReady low in DECODE must not stall
        step("beq_f",   6'b000000, 1'b1, 4'd0, E_FETCH_R);
        step("beq_dec", 6'b000100, 1'b0, 4'd1, E_DECODE);
        step("beq_br",  6'b000000, 1'b0, 4'd8, E_BRANCH);

        // J
        step("j_f",     6'b000000, 1'b1, 4'd0, E_FETCH_R);
        step("j_dec",   6'b000010, 1'b1, 4'd1, E_DECODE);
        step("j_jmp",   6'b000000, 1'b1, 4'd9, E_JUMP);

        // ADDI
        step("addi_f",  6'b000000, 1'b1, 4'd0, E_FETCH_R);
`ifdef MC_ADDI_EN
        step("addi_dec", 6'b001000, 1'b1, 4'd1, E_DECODE);
        step("addi_ex",  6'b000000, 1'b1, 4'd10, E_ADDIEX);
        step("addi_wb",  6'b000000, 1'b1, 4'd11, E_ADDIWB);
`else
        step("addi_dec", 6'b001000, 1'b1, 4'd1, E_DEC_ILL);
`endif
        step("addi_ret", 6'b000000, 1'b0, 4'd0, E_FETCH_W);

        // Unsupported opcode
        step("ill_f",   6'b000000, 1'b1, 4'd0, E_FETCH_R);
        step("ill_dec", 6'b111111, 1'b1, 4'd1, E_DEC_ILL);
        step("ill_ret", 6'b000000, 1'b1, 4'd0, E_FETCH_R);

        // Async reset in the middle of a load read wait
        step("ar_dec",  6'b100011, 1'b1, 4'd1, E_DECODE);
        step("ar_adr",  6'b000000, 1'b1, 4'd2, E_MEMADR);
        step("ar_rd",   6'b000000, 1'b0, 4'd3, E_MEMRD);
        #1;
        rst      = 1'b1;
        MemReady = 1'b1;
        #1;
        chk("ar_async", 4'd0, E_NONE);
        step("ar_hold", 6'b000000, 1'b1, 4'd0, E_NONE);
        rst = 1'b0;
        #1;
        chk("ar_fetch", 4'd0, E_FETCH_R);
        step("ar_r_dec",  6'b000000, 1'b1, 4'd1, E_DECODE);
        step("ar_r_exec", 6'b000000, 1'b1, 4'd6, E_EXEC);
        step("ar_r_rwb",  6'b000000, 1'b1, 4'd7, E_RWB);
        step("ar_next",   6'b000000, 1'b1, 4'd0, E_FETCH_R);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctl.md
# mc_ctl

Multicycle main control sequencer for the MIPS32 core. It replaces the single-cycle opcode decoder when the datapath is rebuilt around one shared memory port, one ALU and holding registers (IR, MDR, A, B, ALUOut). A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects, register and memory strobes, and PC write enables. Memory accesses wait on a ready handshake.

## Interface
Parameters:
- STATE_W, 4, width of the State debug output; must be >= 4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- OpCode  input  6  instr[31:26] from the IR register; sampled only in DECODE.
- MemReady  input  1  memory completes the current access this cycle.
- PCWr  output  1  unconditional PC write.
- PCWrCond  output  1  PC write qualified by ALU Zero, externally.
- PCSrc  output  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- IorD  output  1  memory address select: 0 PC, 1 ALUOut.
- MemRd  output  1  memory read request.
- MemWr  output  1  memory write request.
- IRWr  output  1  IR load.
- RegDst  output  1  write register select: 1 rd, 0 rt.
- RegWr  output  1  register file write.
- MemtoReg  output  1  writeback data select: 1 MDR, 0 ALUOut.
- ALUSrcA  output  1  ALU A select: 0 PC, 1 A register.
- ALUSrcB  output  2  ALU B select: 00 B register, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm << 2.
- ALUOp  output  2  to the ALU control decoder: 00 add, 01 sub, 10 by funct.
- InstrDone  output  1  one-cycle pulse in the final cycle of each instruction.
- IllegalOp  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
- State  output  STATE_W  current state code, zero-extended.

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Any output not listed for a state is 0.
- FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWr and PCWr are both equal to MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - 000000 -> EXEC; 100011 and 101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX (only with the macro).
  - Any other opcode: IllegalOp=1, next state FETCH; no register, memory or PC write occurs.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Goes to MEMRD if the opcode latched in DECODE is LW, otherwise to MEMWR.
- MEMRD: MemRd=1, IorD=1. Wait for MemReady, then go to MEMWB.
- MEMWB: RegWr=1, RegDst=0, MemtoReg=1, InstrDone=1 -> FETCH.
- MEMWR: MemWr=1, IorD=1. Wait for MemReady; in that cycle InstrDone=1 and next state is FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB: RegWr=1, RegDst=1, MemtoReg=0, InstrDone=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWrCond=1, PCSrc=01, InstrDone=1 -> FETCH.
- JUMP: PCWr=1, PCSrc=10, InstrDone=1 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegWr=1, RegDst=0, MemtoReg=0, InstrDone=1 -> FETCH.
- The opcode is captured into an internal 6-bit register in DECODE. Later states use only that captured copy, never the live OpCode.
- Unreachable state codes go to FETCH on the next edge, with all outputs 0.

## Timing
- Outputs are decoded from the state alone (Moore), except the MemReady-qualified strobes (FETCH IRWr/PCWr, MEMWR InstrDone). Those are combinational on MemReady.
- Reset: while rst=1, the state is FETCH, the captured opcode is 0 and every output is 0.
  - This includes MemRd, IRWr and PCWr: FETCH outputs are gated off while rst=1.
  - The first FETCH request occurs in the first cycle after rst deasserts.
- Reset asserted mid-instruction aborts it immediately; no RegWr, MemWr or PCWr is issued afterwards.
- Latency with MemReady tied to 1, in cycles from FETCH entry to the InstrDone cycle inclusive:
  - R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, illegal opcode 2 (no InstrDone).
- Each wait cycle at MemReady=0 adds exactly one cycle. There is no timeout.
- MemReady is ignored in every state except FETCH, MEMRD and MEMWR.

## Configuration
- MC_ADDI_EN defined: opcode 001000 decodes to ADDIEX -> ADDIWB.
- MC_ADDI_EN undefined: ADDIEX/ADDIWB are not built; opcode 001000 takes the illegal path (IllegalOp pulse, return to FETCH).

## Test plan
- Reset asserted for 3 cycles, MemReady=1 -> all outputs 0 during reset; State=0, MemRd=1 and IRWr=1 in the first cycle after release.
- OpCode=000000, MemReady=1 -> States 0,1,6,7; RegWr=1 with RegDst=1 in the 4th cycle; InstrDone pulses once.
- OpCode=100011, MemReady low for 2 cycles in FETCH and 3 cycles in MEMRD -> total 10 cycles; IRWr=1 only in the ready cycle; MEMWB asserts RegWr=1 and MemtoReg=1.
- OpCode=101011 followed by OpCode=000100 -> MemWr=1, IorD=1 in state 5, then PCWrCond=1 with PCSrc=01 and ALUOp=01 in state 8; no RegWr in either instruction.
- OpCode=001000 -> with MC_ADDI_EN: States 0,1,10,11 and RegWr=1 with RegDst=0; without MC_ADDI_EN: IllegalOp=1 in DECODE and back to FETCH, with no RegWr.
- rst pulsed asynchronously while in MEMRD -> State=0 and all outputs 0 before the next clock edge; the following fetch proceeds normally.
